// File: rtl/sigcap_pkg.sv
// sigcap_pkg: shared defaults and FSM state type for sig_capture.
// S_ARMED exists only when SIGCAP_TRIG_EN is defined.
package sigcap_pkg;

    localparam int SIGCAP_AW = 9;
    localparam int SIGCAP_DW = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
`ifdef SIGCAP_TRIG_EN
        ,
        S_ARMED   = 2'd3
`endif
    } state_e;

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM, one write port, one registered read port.
// Ports: clk_i; we_i/waddr_i/wdata_i write; re_i/raddr_i read, rdata_o valid a cycle later.
module dual_port_ram #(
    parameter int AW = 9,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    // Read data only updates on re_i, so a stalled output holds its value.
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sig_capture.sv
// sig_capture: arm, capture len+1 en-qualified samples into a buffer, then drain them
// over a valid/ready stream with out_last and a done pulse. Optional trigger: SIGCAP_TRIG_EN.
// Ports: clk, rst_n (async low); en, mic_in capture; arm, len control; busy, done status;
// out_data/out_valid/out_ready/out_last stream; thr (trigger level, macro builds only).
module sig_capture
    import sigcap_pkg::*;
#(
    parameter int AW = SIGCAP_AW,
    parameter int DW = SIGCAP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef SIGCAP_TRIG_EN
    input  logic [DW-1:0] thr,
`endif
    input  logic          en,
    input  logic [DW-1:0] mic_in,
    input  logic          arm,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          done
);

    state_e        state_q, state_d;
    logic [AW-1:0] len_q, len_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_done_q, rd_done_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;
    logic          ram_we;
    logic          ram_re;
    logic [DW-1:0] ram_rdata;
`ifdef SIGCAP_TRIG_EN
    logic [DW-1:0] prev_q, prev_d;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_done_d   = rd_done_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
`ifdef SIGCAP_TRIG_EN
        prev_d      = prev_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    len_d     = len;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    rd_done_d = 1'b0;
`ifdef SIGCAP_TRIG_EN
                    prev_d    = '1;
                    state_d   = S_ARMED;
`else
                    state_d   = S_CAPTURE;
`endif
                end
            end
`ifdef SIGCAP_TRIG_EN
            S_ARMED: begin
                if (en) begin
                    prev_d = mic_in;
                    // Rising crossing: the crossing sample itself lands at address 0.
                    if (prev_q < thr && mic_in >= thr) begin
                        ram_we = 1'b1;
                        if (wr_ptr_q == len_q) begin
                            state_d = S_DRAIN;
                        end else begin
                            wr_ptr_d = wr_ptr_q + AW'(1);
                            state_d  = S_CAPTURE;
                        end
                    end
                end
            end
`endif
            S_CAPTURE: begin
                if (en) begin
                    ram_we = 1'b1;
                    // No increment on the final write, so a full buffer never wraps.
                    if (wr_ptr_q == len_q) state_d = S_DRAIN;
                    else wr_ptr_d = wr_ptr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                // Issue the next read whenever the output slot is free or being freed.
                if (!rd_done_q && (!out_valid_q || out_ready)) begin
                    ram_re      = 1'b1;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_ptr_q == len_q);
                    if (rd_ptr_q == len_q) rd_done_d = 1'b1;
                    else rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef SIGCAP_TRIG_EN
            prev_q      <= '1;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_done_q   <= rd_done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
`ifdef SIGCAP_TRIG_EN
            prev_q      <= prev_d;
`endif
        end
    end

    dual_port_ram #(
        .AW (AW),
        .DW (DW)
    ) u_buf (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (mic_in),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // RAM read register has no reset; masking keeps out_data at 0 when idle.
    assign out_data  = out_valid_q ? ram_rdata : '0;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_sig_capture.sv
// tb_sig_capture: self-checking bench for sig_capture.
// Table-driven captures, hand sequences and randomized runs against a queue model.
module tb_sig_capture;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] mic_in = '0;
    logic          arm = 1'b0;
    logic [AW-1:0] len = '0;
    logic          busy;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          done;
`ifdef SIGCAP_TRIG_EN
    logic [DW-1:0] thr = '0;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] stim[$];

    always #5 clk = ~clk;

    sig_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SIGCAP_TRIG_EN
        .thr       (thr),
`endif
        .en        (en),
        .mic_in    (mic_in),
        .arm       (arm),
        .len       (len),
        .busy      (busy),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_valid"}, out_valid, 0);
        chk({nm, "_last"}, out_last, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_data"}, out_data, 0);
    endtask

`ifndef SIGCAP_TRIG_EN
    typedef struct {
        int len;
        int start;
        int step;
        int rmode;
        int en_pct;
        bit poke;
        int exp_n;
        int exp_first;
        int exp_last;
    } vec_t;

    // Model: output k of a capture is the k-th en-high sample fed after arm.
    task automatic run_capture(input int l, input int rmode, input int en_pct,
                               input bit poke, input int abort_n,
                               output int n_out, output int first_v, output int last_v);
        int fed = 0;
        int hs = 0;
        int cyc = 0;
        int fed_cyc = -1;
        bit seen_valid = 0;
        bit stall = 0;
        bit pend = 0;
        bit fin = 0;
        logic [DW-1:0] dprev = '0;
        logic lprev = 1'b0;
        first_v = -1;
        last_v = -1;
        @(posedge clk); #1;
        arm = 1'b1;
        len = AW'(l);
        en = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        arm = 1'b0;
        while (!fin && cyc < 6000) begin
            if (abort_n > 0 && hs >= abort_n) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("abort");
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", done, 0);
                    chk("abort_idle", busy, 0);
                end
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end else if (pend) begin
                chk("done_pulse", done, 1);
                chk("done_valid", out_valid, 0);
                chk("done_busy", busy, 0);
                fin = 1;
            end else begin
                chk("busy", busy, 1);
                chk("done_early", done, 0);
                if (stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", out_data, dprev);
                    chk("stall_last", out_last, lprev);
                end
                if (rmode == 0 && hs > 0) chk("thruput", out_valid, 1);
                if (!seen_valid && out_valid) begin
                    seen_valid = 1;
                    chk("latency", (fed_cyc >= 0 && cyc - fed_cyc >= 2 &&
                                    cyc - fed_cyc <= 3), 1);
                end
                en = ($urandom_range(99) < en_pct);
                mic_in = (en && fed <= l) ? stim[fed] : DW'($urandom);
                if (en) begin
                    if (fed == l) fed_cyc = cyc;
                    fed++;
                end
                case (rmode)
                    0: out_ready = 1'b1;
                    1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    default: out_ready = $urandom_range(1);
                endcase
                arm = poke && ($urandom_range(7) == 0);
                len = AW'($urandom);
                if (out_valid && out_ready) begin
                    if (hs <= l) chk("data", out_data, stim[hs]);
                    else chk("extra_out", hs, l);
                    chk("last", out_last, hs == l);
                    if (hs == 0) first_v = out_data;
                    last_v = out_data;
                    if (hs == l) pend = 1;
                    hs++;
                end
                stall = out_valid && !out_ready;
                dprev = out_data;
                lprev = out_last;
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d outputs expected %0d", hs, l + 1);
        end
        if (abort_n <= 0) chk("hs_count", hs, l + 1);
        n_out = hs;
        arm = 1'b0;
        en = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic fill_stim(input int l, input int start, input int step);
        stim.delete();
        for (int k = 0; k <= l; k++) stim.push_back(DW'(start + k * step));
    endtask

    initial begin
        vec_t tbl[7];
        int n, f, lv;
        tbl[0] = '{3,   10,    1,    0, 100, 0, 4,   10,    13};
        tbl[1] = '{0,   'hA5,  0,    0, 100, 0, 1,   'hA5,  'hA5};
        tbl[2] = '{7,   'h20,  3,    1, 100, 0, 8,   'h20,  'h35};
        tbl[3] = '{5,   'hF0,  4,    2, 60,  0, 6,   'hF0,  'h04};
        tbl[4] = '{4,   'h50,  255,  2, 100, 1, 5,   'h50,  'h4C};
        tbl[5] = '{511, 0,     1,    0, 100, 0, 512, 0,     'hFF};
        tbl[6] = '{2,   'h7F,  'h40, 1, 50,  1, 3,   'h7F,  'hFF};

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            fill_stim(tbl[i].len, tbl[i].start, tbl[i].step);
            run_capture(tbl[i].len, tbl[i].rmode, tbl[i].en_pct, tbl[i].poke, 0, n, f, lv);
            chk($sformatf("row%0d_n", i), n, tbl[i].exp_n);
            chk($sformatf("row%0d_first", i), f, tbl[i].exp_first);
            chk($sformatf("row%0d_last", i), lv, tbl[i].exp_last);
        end

        fill_stim(5, 'h31, 7);
        run_capture(5, 0, 100, 0, 2, n, f, lv);
        chk("abort_n", n, 2);
        chk("abort_first", f, 'h31);
        fill_stim(3, 'hC0, 5);
        run_capture(3, 1, 100, 0, 0, n, f, lv);
        chk("fresh_first", f, 'hC0);
        chk("fresh_last", lv, 'hCF);

        for (int r = 0; r < 15; r++) begin
            int l;
            l = ($urandom_range(7) == 0) ? $urandom_range(255) : $urandom_range(20);
            stim.delete();
            for (int k = 0; k <= l; k++) stim.push_back(DW'($urandom));
            run_capture(l, $urandom_range(2), $urandom_range(25, 100),
                        1'($urandom_range(1)), 0, n, f, lv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`else
    initial begin
        logic [DW-1:0] ramp[4];
        logic [DW-1:0] got[$];
        int cyc;
        ramp = '{8'h7E, 8'h7F, 8'h80, 8'h81};
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        thr = 8'h80;
        @(posedge clk); #1;
        arm = 1'b1;
        len = AW'(1);
        @(posedge clk); #1;
        arm = 1'b0;
        chk("armed_busy", busy, 1);
        cyc = 0;
        while (!done && cyc < 200) begin
            en = 1'b1;
            mic_in = (cyc < 4) ? ramp[cyc] : 8'h00;
            out_ready = 1'b1;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                chk("trig_last", out_last, got.size() == 2);
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("trig_done", done, 1);
        chk("trig_count", got.size(), 2);
        chk("trig_first", (got.size() > 0) ? got[0] : 8'hXX, 8'h80);
        chk("trig_second", (got.size() > 1) ? got[1] : 8'hXX, 8'h81);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
`endif

endmodule

// File: doc/sig_capture.md
SIG_CAPTURE -- requirements
Module: sig_capture

Interface
REQ-001 Parameter AW, default 9, buffer address width; buffer depth 2**AW samples.
REQ-002 Parameter DW, default 8, sample data width.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  sample strobe; mic_in valid when high.
REQ-007 mic_in  in  DW  microphone sample, unsigned.
REQ-008 arm  in  1  single-cycle request to start a capture.
REQ-009 len  in  AW  capture length minus one; latched on accepted arm.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 out_data  out  DW  read-back sample.
REQ-012 out_valid  out  1  out_data valid.
REQ-013 out_ready  in  1  downstream accepts when high with out_valid.
REQ-014 out_last  out  1  high with the final sample of a capture.
REQ-015 done  out  1  one-cycle pulse after the final sample handshake.

Function
REQ-016 FSM states: IDLE, ARMED (macro only), CAPTURE, DRAIN.
REQ-017 IDLE: arm high -> latch len, clear write/read pointers, go to CAPTURE (or ARMED with macro).
REQ-018 arm outside IDLE is ignored; len changes outside IDLE are ignored.
REQ-019 CAPTURE: each cycle with en high writes mic_in to address wr_ptr, then wr_ptr increments; en low stalls.
REQ-020 The write at wr_ptr == latched len is the last; the FSM enters DRAIN on the next cycle.
REQ-021 len = 0 captures exactly one sample; len = 2**AW-1 fills the buffer without wrap.
REQ-022 DRAIN: samples are emitted in write order from address 0 to latched len, one per handshake (out_valid & out_ready).
REQ-023 First out_valid is asserted no later than 2 cycles after entering DRAIN (1-cycle synchronous RAM read included).
REQ-024 While out_valid is high and out_ready is low, out_data, out_valid and out_last hold stable.
REQ-025 With out_ready held high, sustained throughput is one sample per cycle after the first.
REQ-026 out_last is high only with the sample from address latched len.
REQ-027 The cycle after the out_last handshake: done = 1, FSM in IDLE, out_valid = 0.
REQ-028 mic_in and en are ignored in DRAIN and IDLE; no buffer writes occur there.

Reset
REQ-029 rst_n low: FSM to IDLE; busy, out_valid, out_last, done = 0; out_data = 0; pointers = 0.
REQ-030 Reset mid-CAPTURE or mid-DRAIN abandons the capture; no done pulse; buffer contents undefined.

Configuration
REQ-031 Macro SIGCAP_TRIG_EN defined: port thr (in, DW) exists; ARMED waits for an en sample with prev < thr and mic_in >= thr; that sample is the first written (address 0); prev resets to 2**DW-1.
REQ-032 SIGCAP_TRIG_EN undefined: no thr port, no ARMED state; arm goes directly to CAPTURE.

Structure
REQ-033 Package sigcap_pkg holds the FSM state enum typedef and the AW/DW default constants.
REQ-034 Buffer storage is one dual_port_ram instance (write port for capture, read port for drain); no other sub-modules.

Verification
REQ-035 Reset, arm, len=3, en constant high, mic_in 10,11,12,13; out_ready high -> out_data 10,11,12,13, out_last on 13, done pulse 1 cycle later.
REQ-036 len=0, mic_in 0xA5 -> exactly one output 0xA5 with out_last=1.
REQ-037 len=7, out_ready toggling 1,0,0,1 repeating -> all 8 samples in order, out_data stable during stalls, no duplicates.
REQ-038 arm pulsed again during CAPTURE and DRAIN -> ignored, latched len unchanged, single done.
REQ-039 rst_n low mid-DRAIN after 2 outputs -> out_valid=0 immediately, busy=0, no done; new arm captures fresh data.
REQ-040 SIGCAP_TRIG_EN, thr=0x80, mic_in ramp 0x7E,0x7F,0x80,0x81 after arm, len=1 -> outputs 0x80,0x81.
